// File: rtl/dekatron_counter_n.sv
// ---------------------------------------------------------------------------
// dekatron_counter_n
//   N-digit decimal up/down loop counter. Each digit is a one-hot 10-state
//   ring (dekatron model); Out is a combinational one-hot -> BCD decode of
//   the rings, so it carries no extra latency.
//   Features: parallel load (Set), count enable, direction (Reverse),
//   combinational Terminal, sticky Overflow / Underflow, single-edge carry
//   across all digits, self-repair of illegal (non one-hot) rings.
//   Optional build macro: COUNTER_SATURATE_EN -- when defined, an enabled
//   step at Terminal holds the count at all-9s (up) / all-0s (down) instead
//   of wrapping. Flags are set identically in both builds.
//   DIGITS must lie in 1..8.
// ---------------------------------------------------------------------------
module dekatron_counter_n #(
    parameter int DIGITS = 2
) (
    input  logic                  Step,
    input  logic                  Rst_n,
    input  logic                  Enable,
    input  logic                  Reverse,
    input  logic                  Set,
    input  logic [4*DIGITS-1:0]   In,
    output logic [4*DIGITS-1:0]   Out,
    output logic                  Terminal,
    output logic                  Overflow,
    output logic                  Underflow
);

`ifdef COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [9:0] RING_POS0 = 10'b00_0000_0001;
    localparam logic [9:0] RING_POS9 = 10'b10_0000_0000;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------

    // BCD digit -> one-hot ring position; digits above 9 clamp to 9.
    function automatic logic [9:0] bcd_to_ring(input logic [3:0] digit);
        logic [3:0] clamped;
        clamped = (digit > 4'd9) ? 4'd9 : digit;
        return RING_POS0 << clamped;
    endfunction

    // One-hot ring -> BCD digit; an illegal ring decodes as 0 until repaired.
    function automatic logic [3:0] ring_to_bcd(input logic [9:0] ring);
        logic [3:0] digit;
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (ring == (RING_POS0 << i)) begin
                digit = 4'(i);
            end
        end
        return digit;
    endfunction

    // Rotate a ring one position: up moves bit i to i+1 (9 -> 0),
    // down moves bit i to i-1 (0 -> 9).
    function automatic logic [9:0] rotate_ring(input logic [9:0] ring,
                                               input logic       down);
        return down ? {ring[0], ring[9:1]} : {ring[8:0], ring[9]};
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [9:0]        ring_q [DIGITS];
    logic [9:0]        ring_d [DIGITS];
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic [DIGITS-1:0] ring_legal;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS:0]   carry_up;     // carry_up[k]: all digits below k are 9
    logic [DIGITS:0]   carry_dn;     // carry_dn[k]: all digits below k are 0
    logic [DIGITS-1:0] digit_step;
    logic              hold_count;

    // Classify each ring and resolve the carry chains for both directions.
    // An illegal ring is neither at 9 nor at 0, so it never propagates carry.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        ring_legal  = '0;
        at_max      = '0;
        at_min      = '0;
        carry_up    = '0;
        carry_dn    = '0;
        carry_up[0] = 1'b1;
        carry_dn[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            ring_legal[k] = $onehot(ring_q[k]);
            at_max[k]     = (ring_q[k] == RING_POS9);
            at_min[k]     = (ring_q[k] == RING_POS0);
            carry_up[k+1] = carry_up[k] & at_max[k];
            carry_dn[k+1] = carry_dn[k] & at_min[k];
        end
    end

    // Terminal looks only at the count and direction, never at Enable.
    always_comb begin
        Terminal   = Reverse ? carry_dn[DIGITS] : carry_up[DIGITS];
        digit_step = Reverse ? carry_dn[DIGITS-1:0] : carry_up[DIGITS-1:0];
        hold_count = SATURATE & Terminal;
    end

    // Next-state: Set beats Enable beats hold; illegal rings are repaired last
    // so the repair wins over both load and count.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            ring_d[k] = ring_q[k];
        end
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (Set) begin
            for (int k = 0; k < DIGITS; k++) begin
                ring_d[k] = bcd_to_ring(In[4*k +: 4]);
            end
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (Enable) begin
            if (Terminal) begin
                if (Reverse) begin
                    underflow_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (!hold_count) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (digit_step[k]) begin
                        ring_d[k] = rotate_ring(ring_q[k], Reverse);
                    end
                end
            end
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (!ring_legal[k]) begin
                ring_d[k] = RING_POS0;
            end
        end
    end

    // Ring and flag registers with asynchronous reset to count zero.
    always_ff @(posedge Step or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: the rings are control state, not a storage array; every
            // ring must reset to a legal position so Out is 0 straight away.
            for (int k = 0; k < DIGITS; k++) begin
                ring_q[k] <= RING_POS0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of the others, regardless of statement order.
            for (int k = 0; k < DIGITS; k++) begin
                ring_q[k] <= ring_d[k];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Decode rings to BCD for the display / comparator outputs.
    always_comb begin
        Out = '0;
        for (int k = 0; k < DIGITS; k++) begin
            Out[4*k +: 4] = ring_to_bcd(ring_q[k]);
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_dekatron_counter_n.sv
// ---------------------------------------------------------------------------
// tb_dekatron_counter_n
//   Directed bench for dekatron_counter_n with DIGITS=2. Expected values are
//   written by hand; where the COUNTER_SATURATE_EN build differs from the
//   wrap build, both values are given and selected by SAT.
// ---------------------------------------------------------------------------
module tb_dekatron_counter_n;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int DIGITS = 2;

    logic              Step;
    logic              Rst_n;
    logic              Enable;
    logic              Reverse;
    logic              Set;
    logic [7:0]        In;
    logic [7:0]        Out;
    logic              Terminal;
    logic              Overflow;
    logic              Underflow;

    int errors = 0;
    int checks = 0;

    dekatron_counter_n #(.DIGITS(DIGITS)) dut (
        .Step      (Step),
        .Rst_n     (Rst_n),
        .Enable    (Enable),
        .Reverse   (Reverse),
        .Set       (Set),
        .In        (In),
        .Out       (Out),
        .Terminal  (Terminal),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial Step = 1'b0;
    always #5 Step = ~Step;

    // Wait for one rising Step edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Step);
        #1;
    endtask

    // Load a value with Set for one edge, then drop Set and Enable.
    task automatic load(input logic [7:0] value);
        Set = 1'b1; Enable = 1'b0; In = value;
        tick();
        Set = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Enable = 1'b0; Reverse = 1'b0; Set = 1'b0; In = 8'h00;
        #12;
        checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", Out); end
        checks++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got ovf=%b udf=%b want 0 0", Overflow, Underflow); end
        checks++; if (Terminal !== 1'b0) begin errors++; $display("FAIL reset_term_up: got %b want 0", Terminal); end
        Reverse = 1'b1; #1;
        checks++; if (Terminal !== 1'b1) begin errors++; $display("FAIL reset_term_dn: got %b want 1", Terminal); end
        Reverse = 1'b0;
        @(negedge Step); Rst_n = 1'b1;
        tick();
        checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_hold: got %h want 00", Out); end
    endtask

    task automatic test_load_overflow();
        // Set and Enable together: the load wins.
        Set = 1'b1; Enable = 1'b1; Reverse = 1'b0; In = 8'h98;
        tick();
        Set = 1'b0;
        checks++; if (Out !== 8'h98) begin errors++; $display("FAIL load_98: got %h want 98", Out); end
        tick();
        checks++; if (Out !== 8'h99 || Terminal !== 1'b1 || Overflow !== 1'b0) begin errors++;
            $display("FAIL up_99: got out=%h term=%b ovf=%b want 99 1 0", Out, Terminal, Overflow); end
        tick();
        checks++; if (Out !== (SAT ? 8'h99 : 8'h00) || Overflow !== 1'b1 || Underflow !== 1'b0) begin errors++;
            $display("FAIL up_wrap: got out=%h ovf=%b udf=%b want %h 1 0", Out, Overflow, Underflow, SAT ? 8'h99 : 8'h00); end
        tick();
        checks++; if (Out !== (SAT ? 8'h99 : 8'h01) || Overflow !== 1'b1) begin errors++;
            $display("FAIL up_after_wrap: got out=%h ovf=%b want %h 1", Out, Overflow, SAT ? 8'h99 : 8'h01); end
        Enable = 1'b0;
    endtask

    task automatic test_underflow();
        load(8'h00);
        Reverse = 1'b1; #1;
        checks++; if (Terminal !== 1'b1) begin errors++; $display("FAIL dn_term: got %b want 1", Terminal); end
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        checks++; if (Out !== (SAT ? 8'h00 : 8'h99) || Underflow !== 1'b1 || Overflow !== 1'b0) begin errors++;
            $display("FAIL dn_wrap: got out=%h udf=%b ovf=%b want %h 1 0", Out, Underflow, Overflow, SAT ? 8'h00 : 8'h99); end
        load(8'h05);
        checks++; if (Out !== 8'h05 || Underflow !== 1'b0 || Overflow !== 1'b0) begin errors++;
            $display("FAIL set_clears: got out=%h udf=%b ovf=%b want 05 0 0", Out, Underflow, Overflow); end
        Reverse = 1'b0;
    endtask

    task automatic test_clamp();
        Set = 1'b1; Enable = 1'b1; Reverse = 1'b0; In = 8'h4F;
        tick();
        checks++; if (Out !== 8'h49) begin errors++; $display("FAIL clamp_4F: got %h want 49", Out); end
        In = 8'hAB;
        tick();
        checks++; if (Out !== 8'h99) begin errors++; $display("FAIL clamp_AB: got %h want 99", Out); end
        Set = 1'b0; Enable = 1'b0;
    endtask

    task automatic test_hold_and_carry();
        load(8'h49);
        Reverse = 1'b1;
        tick();
        Reverse = 1'b0;
        tick();
        checks++; if (Out !== 8'h49 || Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++;
            $display("FAIL hold: got out=%h ovf=%b udf=%b want 49 0 0", Out, Overflow, Underflow); end
        // Carry into the tens digit in one edge, then borrow back, alternating direction.
        load(8'h19);
        Enable = 1'b1; Reverse = 1'b0;
        tick();
        checks++; if (Out !== 8'h20) begin errors++; $display("FAIL carry_up: got %h want 20", Out); end
        Reverse = 1'b1;
        tick();
        checks++; if (Out !== 8'h19) begin errors++; $display("FAIL borrow_dn: got %h want 19", Out); end
        tick();
        checks++; if (Out !== 8'h18 || Terminal !== 1'b0) begin errors++;
            $display("FAIL dn_mid: got out=%h term=%b want 18 0", Out, Terminal); end
        Enable = 1'b0; Reverse = 1'b0;
    endtask

    task automatic test_long_run();
        load(8'h00);
        Enable = 1'b1; Reverse = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 99) begin
                checks++; if (Out !== 8'h99 || Overflow !== 1'b0) begin errors++;
                    $display("FAIL long_up99: got out=%h ovf=%b want 99 0", Out, Overflow); end
            end
            if (i == 100) begin
                checks++; if (Overflow !== 1'b1 || Out !== (SAT ? 8'h99 : 8'h00)) begin errors++;
                    $display("FAIL long_up100: got out=%h ovf=%b want %h 1", Out, Overflow, SAT ? 8'h99 : 8'h00); end
            end
        end
        checks++; if (Out !== (SAT ? 8'h99 : 8'h20)) begin errors++;
            $display("FAIL long_up120: got %h want %h", Out, SAT ? 8'h99 : 8'h20); end
        Reverse = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            tick();
        end
        checks++; if (Out !== 8'h00 || Overflow !== 1'b1 || Underflow !== 1'b1) begin errors++;
            $display("FAIL long_dn120: got out=%h ovf=%b udf=%b want 00 1 1", Out, Overflow, Underflow); end
        Enable = 1'b0; Reverse = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        Enable = 1'b1; Reverse = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
        end
        checks++; if (Out !== 8'h37 || Overflow !== 1'b1) begin errors++;
            $display("FAIL pre_reset: got out=%h ovf=%b want 37 1", Out, Overflow); end
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Out !== 8'h00 || Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++;
            $display("FAIL async_reset: got out=%h ovf=%b udf=%b want 00 0 0", Out, Overflow, Underflow); end
        @(posedge Step); #2;
        checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_held: got %h want 00", Out); end
        // Release while Step is high, then count once.
        Rst_n = 1'b1;
        tick();
        checks++; if (Out !== 8'h01) begin errors++; $display("FAIL post_reset: got %h want 01", Out); end
        Enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_overflow();
        test_underflow();
        test_clamp();
        test_hold_and_carry();
        test_long_run();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
